// File: rtl/keccak_perm_ctrl.sv
// Control FSM for the Keccak-f[1600] sponge core: sequences state clear, absorb XOR,
// round stepping (optionally unrolled) and multi-block squeeze with valid/ready handshakes.
module keccak_perm_ctrl #(
    parameter int unsigned NUM_ROUNDS       = 24,
    parameter int unsigned ROUNDS_PER_CYCLE = 1,
    parameter int unsigned OUT_BLOCKS_W     = 16,
    parameter int unsigned ROUND_IDX_W      = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [1:0]              mode_i,
    input  logic [OUT_BLOCKS_W-1:0] out_blocks_i,
    input  logic                    in_valid_i,
    input  logic                    in_last_i,
    output logic                    in_ready_o,
    input  logic                    out_ready_i,
    output logic                    out_valid_o,
    output logic                    out_last_o,
    output logic                    state_reset_o,
    output logic                    absorb_en_o,
    output logic                    round_en_o,
    output logic [ROUND_IDX_W-1:0]  round_idx_o,
    output logic [1:0]              rate_sel_o,
    output logic                    busy_o,
    output logic                    done_o
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWaitIn  = 2'd1,
        StPerm    = 2'd2,
        StWaitOut = 2'd3
    } state_e;

    localparam logic [ROUND_IDX_W-1:0]  Step    = ROUND_IDX_W'(ROUNDS_PER_CYCLE);
    localparam logic [ROUND_IDX_W-1:0]  LastCnt = ROUND_IDX_W'(NUM_ROUNDS - ROUNDS_PER_CYCLE);
    localparam logic [OUT_BLOCKS_W-1:0] OneBlk  = OUT_BLOCKS_W'(1);

    state_e                  state_q, state_d;
    logic [ROUND_IDX_W-1:0]  cnt_q, cnt_d;
    logic [OUT_BLOCKS_W-1:0] rem_q, rem_d;
    logic                    last_q, last_d;
    logic [1:0]              rate_q, rate_d;

    logic in_ready, absorb_en, out_valid, out_last, done, state_reset, round_en;

    // Next-state logic and Mealy strobes.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        last_d      = last_q;
        rate_d      = rate_q;
        in_ready    = 1'b0;
        absorb_en   = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        done        = 1'b0;
        state_reset = 1'b0;
        round_en    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_reset = 1'b1;
                    rate_d      = mode_i;
                    // SHA3 modes have a fixed single-block digest; zero request means one block.
                    if (mode_i[1] || (out_blocks_i == '0)) begin
                        rem_d = OneBlk;
                    end else begin
                        rem_d = out_blocks_i;
                    end
                    state_d = StWaitIn;
                end
            end
            StWaitIn: begin
                if (in_valid_i) begin
                    in_ready  = 1'b1;
                    absorb_en = 1'b1;
                    last_d    = in_last_i;
                    cnt_d     = '0;
                    state_d   = StPerm;
                end
            end
            StPerm: begin
                round_en = 1'b1;
                if (cnt_q == LastCnt) begin
                    cnt_d   = '0;
                    // last_q stays set through squeezing, so squeezes return to WAIT_OUT.
                    state_d = last_q ? StWaitOut : StWaitIn;
                end else begin
                    cnt_d = cnt_q + Step;
                end
            end
            StWaitOut: begin
                if (out_ready_i) begin
                    out_valid = 1'b1;
                    if (rem_q == OneBlk) begin
                        out_last = 1'b1;
                        done     = 1'b1;
                        state_d  = StIdle;
                    end else begin
                        rem_d   = rem_q - OneBlk;
                        state_d = StPerm;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rem_q   <= '0;
            last_q  <= 1'b0;
            rate_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            last_q  <= last_d;
            rate_q  <= rate_d;
        end
    end

    // Input-dependent strobes are gated so every output is 0 while reset is held.
    assign in_ready_o    = rst_n & in_ready;
    assign absorb_en_o   = rst_n & absorb_en;
    assign out_valid_o   = rst_n & out_valid;
    assign out_last_o    = rst_n & out_last;
    assign done_o        = rst_n & done;
    assign state_reset_o = rst_n & state_reset;
    assign round_en_o    = round_en;
    assign round_idx_o   = round_en ? cnt_q : '0;
    assign rate_sel_o    = rate_q;
    assign busy_o        = (state_q != StIdle);

endmodule
